// File: rtl/sddr_port_arbiter.sv
// Round-robin arbiter sharing the DDR controller data command/response port among NUM_PORTS requesters.
// Optional macro SDDR_ARB_PORT0_PRIORITY_EN gives port 0 fixed top priority over the round-robin ports.
module sddr_port_arbiter #(
    parameter int NUM_PORTS     = 3,
    parameter int ADDRESS_BITS  = 27,
    parameter int CMD_DATA_BITS = 128
) (
    input  logic                               cpu_clock_i,
    input  logic                               reset_n_i,
    input  logic [NUM_PORTS-1:0]               req_valid_i,
    input  logic [NUM_PORTS*ADDRESS_BITS-1:0]  req_address_i,
    input  logic [NUM_PORTS-1:0]               req_write_i,
    input  logic [NUM_PORTS*CMD_DATA_BITS-1:0] req_data_i,
    output logic [NUM_PORTS-1:0]               req_ack_o,
    output logic [NUM_PORTS-1:0]               rsp_valid_o,
    output logic [CMD_DATA_BITS-1:0]           rsp_data_o,
    output logic                               data_cmd_valid_o,
    output logic [ADDRESS_BITS-1:0]            data_cmd_address_o,
    output logic                               data_cmd_write_o,
    output logic [CMD_DATA_BITS-1:0]           data_cmd_data_o,
    input  logic                               data_cmd_ack_i,
    input  logic                               data_rsp_ready_i,
    input  logic [CMD_DATA_BITS-1:0]           data_rsp_data_i,
    output logic                               busy_o,
    output logic                               rsp_stray_o
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_ISSUE    = 2'd1,
        ARB_WAIT_RSP = 2'd2
    } arb_state_e;

    arb_state_e                 state_q,      state_d;
    logic [IDX_W-1:0]           last_grant_q, last_grant_d;
    logic [IDX_W-1:0]           grant_q,      grant_d;
    logic [ADDRESS_BITS-1:0]    addr_q,       addr_d;
    logic                       write_q,      write_d;
    logic [CMD_DATA_BITS-1:0]   data_q,       data_d;
    logic [NUM_PORTS-1:0]       rsp_valid_q,  rsp_valid_d;
    logic [CMD_DATA_BITS-1:0]   rsp_data_q,   rsp_data_d;
    logic                       stray_q,      stray_d;

    logic                       pick_found;
    logic [IDX_W-1:0]           pick_idx;
    logic [IDX_W-1:0]           cand;
    logic [NUM_PORTS-1:0]       req_ack;

    // Scan starts one past the last winner so every other valid port gets a turn first.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
`ifdef SDDR_ARB_PORT0_PRIORITY_EN
        if (req_valid_i[0]) begin
            pick_found = 1'b1;
            pick_idx   = '0;
        end else begin
            for (int k = 1; k <= NUM_PORTS; k++) begin
                cand = IDX_W'((int'(last_grant_q) + k) % NUM_PORTS);
                if (!pick_found && (cand != '0) && req_valid_i[cand]) begin
                    pick_found = 1'b1;
                    pick_idx   = cand;
                end
            end
        end
`else
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = IDX_W'((int'(last_grant_q) + k) % NUM_PORTS);
            if (!pick_found && req_valid_i[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
`endif
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        addr_d       = addr_q;
        write_d      = write_q;
        data_d       = data_q;
        rsp_valid_d  = '0;
        rsp_data_d   = rsp_data_q;
        stray_d      = stray_q;
        req_ack      = '0;

        if (data_rsp_ready_i && (state_q != ARB_WAIT_RSP)) begin
            stray_d = 1'b1;
        end

        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    req_ack[pick_idx] = 1'b1;
                    addr_d  = req_address_i[int'(pick_idx)*ADDRESS_BITS +: ADDRESS_BITS];
                    write_d = req_write_i[pick_idx];
                    data_d  = req_data_i[int'(pick_idx)*CMD_DATA_BITS +: CMD_DATA_BITS];
                    grant_d = pick_idx;
`ifdef SDDR_ARB_PORT0_PRIORITY_EN
                    if (pick_idx != '0) begin
                        last_grant_d = pick_idx;
                    end
`else
                    last_grant_d = pick_idx;
`endif
                    state_d = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                // The controller returns nothing for writes, so only reads wait.
                if (data_cmd_ack_i) begin
                    state_d = write_q ? ARB_IDLE : ARB_WAIT_RSP;
                end
            end
            ARB_WAIT_RSP: begin
                if (data_rsp_ready_i) begin
                    rsp_data_d           = data_rsp_data_i;
                    rsp_valid_d[grant_q] = 1'b1;
                    state_d              = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge cpu_clock_i) begin
        if (!reset_n_i) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= IDX_W'(NUM_PORTS - 1);
            grant_q      <= '0;
            addr_q       <= '0;
            write_q      <= 1'b0;
            data_q       <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            stray_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            addr_q       <= addr_d;
            write_q      <= write_d;
            data_q       <= data_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            stray_q      <= stray_d;
        end
    end

    assign req_ack_o          = req_ack;
    assign rsp_valid_o        = rsp_valid_q;
    assign rsp_data_o         = rsp_data_q;
    assign data_cmd_valid_o   = (state_q == ARB_ISSUE);
    assign data_cmd_address_o = addr_q;
    assign data_cmd_write_o   = write_q;
    assign data_cmd_data_o    = data_q;
    assign busy_o             = (state_q != ARB_IDLE);
    assign rsp_stray_o        = stray_q;

endmodule

// File: tb/tb_sddr_port_arbiter.sv
// Directed and random checks of sddr_port_arbiter against a transaction-level reference model.
module tb_sddr_port_arbiter;

    localparam int N  = 3;
    localparam int AW = 27;
    localparam int DW = 128;

    logic              clk = 1'b0;
    logic              reset_n_i = 1'b0;
    logic [N-1:0]      req_valid_i = '0;
    logic [N*AW-1:0]   req_address_i = '0;
    logic [N-1:0]      req_write_i = '0;
    logic [N*DW-1:0]   req_data_i = '0;
    logic [N-1:0]      req_ack_o;
    logic [N-1:0]      rsp_valid_o;
    logic [DW-1:0]     rsp_data_o;
    logic              data_cmd_valid_o;
    logic [AW-1:0]     data_cmd_address_o;
    logic              data_cmd_write_o;
    logic [DW-1:0]     data_cmd_data_o;
    logic              data_cmd_ack_i = 1'b0;
    logic              data_rsp_ready_i = 1'b0;
    logic [DW-1:0]     data_rsp_data_i = '0;
    logic              busy_o;
    logic              rsp_stray_o;

    always #5 clk = ~clk;

    sddr_port_arbiter #(.NUM_PORTS(N), .ADDRESS_BITS(AW), .CMD_DATA_BITS(DW)) dut (
        .cpu_clock_i(clk), .reset_n_i(reset_n_i),
        .req_valid_i(req_valid_i), .req_address_i(req_address_i),
        .req_write_i(req_write_i), .req_data_i(req_data_i), .req_ack_o(req_ack_o),
        .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
        .data_cmd_valid_o(data_cmd_valid_o), .data_cmd_address_o(data_cmd_address_o),
        .data_cmd_write_o(data_cmd_write_o), .data_cmd_data_o(data_cmd_data_o),
        .data_cmd_ack_i(data_cmd_ack_i), .data_rsp_ready_i(data_rsp_ready_i),
        .data_rsp_data_i(data_rsp_data_i), .busy_o(busy_o), .rsp_stray_o(rsp_stray_o)
    );

    // Requesters: one pending request per port, held until accepted.
    bit            pend [N];
    logic [AW-1:0] p_addr [N];
    bit            p_wr [N];
    logic [DW-1:0] p_data [N];

    // Controller behaviour: 0 never acks, 1 always acks, 2 acks at random.
    int            ack_mode = 0;
    int            rsp_delay = 3;
    bit            rsp_rand = 0;
    bit            rsp_armed = 0;
    int            rsp_timer = 0;
    bit            stray_pulse = 0;
    bit            rsp_fixed_en = 0;
    logic [DW-1:0] rsp_fixed;

    // Reference model: one transaction slot described by its phase.
    typedef enum {M_IDLE, M_ISSUE, M_WAIT} mphase_e;
    mphase_e       m_phase;
    int            m_last, m_owner;
    logic [AW-1:0] m_addr;
    bit            m_wr;
    logic [DW-1:0] m_data;
    logic [N-1:0]  m_rsp_vld;
    logic [DW-1:0] m_rsp_data;
    bit            m_stray;

    int n_chk = 0;
    int n_fail = 0;
    int grant_log[$];
    int rsp_log[$];

    function automatic int pick(logic [N-1:0] v, int last);
`ifdef SDDR_ARB_PORT0_PRIORITY_EN
        if (v[0]) return 0;
        for (int k = 1; k <= N; k++) begin
            int p = (last + k) % N;
            if (p != 0 && v[p]) return p;
        end
`else
        for (int k = 1; k <= N; k++) begin
            int p = (last + k) % N;
            if (v[p]) return p;
        end
`endif
        return -1;
    endfunction

    function automatic int exp_rr3(int k);
`ifdef SDDR_ARB_PORT0_PRIORITY_EN
        return 0;
`else
        return k % 3;
`endif
    endfunction

    function automatic int exp_p02(int k);
`ifdef SDDR_ARB_PORT0_PRIORITY_EN
        return 0;
`else
        return (k % 2 == 0) ? 0 : 2;
`endif
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic new_req(input int p, input bit wr, input logic [AW-1:0] a);
        pend[p]   = 1'b1;
        p_wr[p]   = wr;
        p_addr[p] = a;
        p_data[p] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid_i[i]             = pend[i];
            req_write_i[i]             = p_wr[i];
            req_address_i[i*AW +: AW]  = p_addr[i];
            req_data_i[i*DW +: DW]     = p_data[i];
        end
        data_cmd_ack_i   = (ack_mode == 1) ? 1'b1 : (ack_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        data_rsp_ready_i = 1'b0;
        data_rsp_data_i  = {$urandom, $urandom, $urandom, $urandom};
        if (rsp_armed) begin
            if (rsp_timer == 0) begin
                data_rsp_ready_i = 1'b1;
                rsp_armed = 1'b0;
                if (rsp_fixed_en) data_rsp_data_i = rsp_fixed;
            end else begin
                rsp_timer--;
            end
        end
        if (stray_pulse) begin
            data_rsp_ready_i = 1'b1;
            stray_pulse = 1'b0;
        end
    endtask

    task automatic settle();
        drive();
        #2;
    endtask

    // Compare every output with the model, then advance model and clock by one edge.
    task automatic finish_cycle();
        logic [N-1:0] exp_ack;
        int g;
        g = (m_phase == M_IDLE) ? pick(req_valid_i, m_last) : -1;
        exp_ack = '0;
        if (g >= 0) exp_ack[g] = 1'b1;
        chk("req_ack", req_ack_o, exp_ack);
        chk("busy", busy_o, m_phase != M_IDLE);
        chk("cmd_valid", data_cmd_valid_o, m_phase == M_ISSUE);
        if (m_phase == M_ISSUE) begin
            chk("cmd_addr", data_cmd_address_o, m_addr);
            chk("cmd_write", data_cmd_write_o, m_wr);
            chk("cmd_data", data_cmd_data_o, m_data);
        end
        chk("rsp_valid", rsp_valid_o, m_rsp_vld);
        chk("rsp_data", rsp_data_o, m_rsp_data);
        chk("rsp_stray", rsp_stray_o, m_stray);
        for (int i = 0; i < N; i++) begin
            if (req_ack_o[i]) grant_log.push_back(i);
            if (rsp_valid_o[i]) rsp_log.push_back(i);
        end

        m_rsp_vld = '0;
        if (data_rsp_ready_i && m_phase != M_WAIT) m_stray = 1'b1;
        case (m_phase)
            M_IDLE: if (g >= 0) begin
                m_addr  = p_addr[g];
                m_wr    = p_wr[g];
                m_data  = p_data[g];
                m_owner = g;
`ifdef SDDR_ARB_PORT0_PRIORITY_EN
                if (g != 0) m_last = g;
`else
                m_last = g;
`endif
                m_phase = M_ISSUE;
                pend[g] = 1'b0;
            end
            M_ISSUE: if (data_cmd_ack_i) begin
                if (m_wr) begin
                    m_phase = M_IDLE;
                end else begin
                    m_phase   = M_WAIT;
                    rsp_armed = 1'b1;
                    rsp_timer = rsp_rand ? $urandom_range(0, 6) : rsp_delay;
                end
            end
            default: if (data_rsp_ready_i) begin
                m_rsp_vld[m_owner] = 1'b1;
                m_rsp_data = data_rsp_data_i;
                m_phase    = M_IDLE;
            end
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        settle();
        finish_cycle();
    endtask

    task automatic do_reset();
        rsp_armed   = 1'b0;
        stray_pulse = 1'b0;
        reset_n_i   = 1'b0;
        drive();
        @(posedge clk);
        #1;
        reset_n_i  = 1'b1;
        m_phase    = M_IDLE;
        m_last     = N - 1;
        m_owner    = 0;
        m_addr     = '0;
        m_wr       = 1'b0;
        m_data     = '0;
        m_rsp_vld  = '0;
        m_rsp_data = '0;
        m_stray    = 1'b0;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        grant_log.delete();
        rsp_log.delete();
    endtask

    task automatic check_all_zero(input string tag);
        settle();
        chk({tag, "_ack"}, req_ack_o, '0);
        chk({tag, "_rsp_valid"}, rsp_valid_o, '0);
        chk({tag, "_rsp_data"}, rsp_data_o, '0);
        chk({tag, "_cmd_valid"}, data_cmd_valid_o, '0);
        chk({tag, "_cmd_addr"}, data_cmd_address_o, '0);
        chk({tag, "_cmd_write"}, data_cmd_write_o, '0);
        chk({tag, "_cmd_data"}, data_cmd_data_o, '0);
        chk({tag, "_busy"}, busy_o, '0);
        chk({tag, "_stray"}, rsp_stray_o, '0);
    endtask

    initial begin
        logic [AW-1:0] hold_addr;
        logic [DW-1:0] hold_data;
        rsp_fixed = {32'hDEAD_0000, 64'h0, 32'h0000_BEEF};

        // Reset state, then a single port-1 read with slow ack and late response.
        do_reset();
        check_all_zero("reset");
        finish_cycle();
        new_req(1, 1'b0, 27'h0001234);
        ack_mode = 0; rsp_delay = 10; rsp_fixed_en = 1;
        settle();
        chk("t1_req_ack", req_ack_o, 3'b010);
        finish_cycle();
        settle();
        chk("t1_cmd_addr", data_cmd_address_o, 27'h0001234);
        chk("t1_cmd_write", data_cmd_write_o, 1'b0);
        finish_cycle();
        step();
        ack_mode = 1;
        step();
        ack_mode = 0;
        for (int c = 0; c < 14; c++) step();
        chk("t1_rsp_count", rsp_log.size(), 1);
        if (rsp_log.size() > 0) chk("t1_rsp_port", rsp_log[0], 1);
        chk("t1_rsp_data", rsp_data_o, rsp_fixed);
        rsp_fixed_en = 0;

        // All ports streaming writes with the controller always ready.
        do_reset();
        ack_mode = 1;
        for (int c = 0; c < 12; c++) begin
            for (int i = 0; i < N; i++) if (!pend[i]) new_req(i, 1'b1, AW'($urandom));
            step();
        end
        chk("t2_grants", grant_log.size(), 6);
        for (int k = 0; k < grant_log.size() && k < 6; k++) chk("t2_order", grant_log[k], exp_rr3(k));
        chk("t2_no_rsp", rsp_log.size(), 0);

        // Stalled controller: command must hold and nobody else gets in.
        do_reset();
        ack_mode = 0;
        new_req(2, 1'b1, AW'($urandom));
        hold_addr = p_addr[2];
        hold_data = p_data[2];
        step();
        new_req(0, 1'b0, AW'($urandom));
        new_req(1, 1'b1, AW'($urandom));
        for (int c = 0; c < 20; c++) begin
            settle();
            chk("t3_hold_valid", data_cmd_valid_o, 1'b1);
            chk("t3_hold_addr", data_cmd_address_o, hold_addr);
            chk("t3_hold_data", data_cmd_data_o, hold_data);
            chk("t3_no_ack", req_ack_o, '0);
            chk("t3_busy", busy_o, 1'b1);
            finish_cycle();
        end
        ack_mode = 1;
        for (int c = 0; c < 8; c++) step();

        // Unexpected response in idle is sticky until reset.
        do_reset();
        stray_pulse = 1;
        step();
        for (int c = 0; c < 4; c++) begin
            settle();
            chk("t4_stray", rsp_stray_o, 1'b1);
            chk("t4_rsp_valid", rsp_valid_o, '0);
            finish_cycle();
        end
        do_reset();
        settle();
        chk("t4_stray_cleared", rsp_stray_o, 1'b0);
        finish_cycle();

        // Reset while waiting for a read response.
        ack_mode = 1; rsp_delay = 40;
        new_req(1, 1'b0, AW'($urandom));
        step();
        step();
        settle();
        chk("t5_busy_wait", busy_o, 1'b1);
        finish_cycle();
        do_reset();
        check_all_zero("t5_reset");
        finish_cycle();
        new_req(0, 1'b1, AW'($urandom));
        new_req(2, 1'b1, AW'($urandom));
        settle();
        chk("t5_first_grant", req_ack_o, 3'b001);
        finish_cycle();

        // Ports 0 and 2 both streaming.
        do_reset();
        ack_mode = 1;
        for (int c = 0; c < 8; c++) begin
            if (!pend[0]) new_req(0, 1'b1, AW'($urandom));
            if (!pend[2]) new_req(2, 1'b1, AW'($urandom));
            step();
        end
        chk("t6_grants", grant_log.size(), 4);
        for (int k = 0; k < grant_log.size() && k < 4; k++) chk("t6_order", grant_log[k], exp_p02(k));

        // Random traffic against the model.
        do_reset();
        ack_mode = 2; rsp_rand = 1;
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++)
                if (!pend[i] && $urandom_range(0, 2) == 0) new_req(i, 1'($urandom_range(0, 1)), AW'($urandom));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
